// File: rtl/hamming_stream_src.sv
// Word-to-bit serializer feeding the bit-serial Hamming distance accumulator.
// Streams N bit pairs LSB first, clears the counter up front and captures its count at the end.
module hamming_stream_src #(
  parameter int N  = 1600,
  parameter int W  = 32,
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_y,
  output logic          x_bit,
  output logic          y_bit,
  output logic          bit_valid,
  output logic          acc_clr,
  input  logic [CW-1:0] res_in,
  output logic [CW-1:0] result,
  output logic          done,
  output logic          busy
);

  localparam int NW   = (N + W - 1) / W;
  localparam int LAST = N - (NW - 1) * W;
  localparam int BCW  = $clog2(N + 1);
  localparam int WCW  = $clog2(NW + 1);
  localparam int LCW  = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

  state_t         state;
  logic [W-1:0]   sr_x, sr_y, buf_x, buf_y;
  logic [LCW-1:0] sr_len, buf_len;
  logic           buf_vld;
  logic [BCW-1:0] bit_cnt;
  logic [WCW-1:0] word_cnt;

  logic           emit, sr_last, sr_free, accept;
  logic [LCW-1:0] in_len;

  // Every output is a decode of registered state; nothing depends on in_valid.
  assign busy      = (state != IDLE);
  assign acc_clr   = (state == CLEAR);
  assign emit      = (state == STREAM) && (sr_len != '0);
  assign sr_last   = emit && (sr_len == LCW'(1));
  assign sr_free   = (sr_len == '0) || sr_last;
  assign in_ready  = busy && !buf_vld && (word_cnt < WCW'(NW));
  assign accept    = in_valid && in_ready;
  // The final word only carries the bits left over once N is reached.
  assign in_len    = (word_cnt == WCW'(NW - 1)) ? LCW'(LAST) : LCW'(W);
  assign bit_valid = emit;
  assign x_bit     = emit & sr_x[0];
  assign y_bit     = emit & sr_y[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sr_x     <= '0;
      sr_y     <= '0;
      sr_len   <= '0;
      buf_x    <= '0;
      buf_y    <= '0;
      buf_len  <= '0;
      buf_vld  <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) word_cnt <= word_cnt + WCW'(1);
      if (emit)   bit_cnt  <= bit_cnt + BCW'(1);

      // A word goes straight into the shifters when they drain this cycle, else it waits in the buffer.
      if (sr_free) begin
        if (buf_vld) begin
          sr_x    <= buf_x;
          sr_y    <= buf_y;
          sr_len  <= buf_len;
          buf_vld <= 1'b0;
        end else if (accept) begin
          sr_x   <= in_x;
          sr_y   <= in_y;
          sr_len <= in_len;
        end else begin
          sr_len <= '0;
        end
      end else begin
        if (emit) begin
          sr_x   <= sr_x >> 1;
          sr_y   <= sr_y >> 1;
          sr_len <= sr_len - LCW'(1);
        end
        if (accept) begin
          buf_x   <= in_x;
          buf_y   <= in_y;
          buf_len <= in_len;
          buf_vld <= 1'b1;
        end
      end

      case (state)
        IDLE: if (start) begin
          state    <= CLEAR;
          result   <= '0;
          bit_cnt  <= '0;
          word_cnt <= '0;
          sr_len   <= '0;
          buf_vld  <= 1'b0;
        end
        CLEAR:  state <= STREAM;
        STREAM: if (emit && bit_cnt == BCW'(N - 1)) state <= DONE;
        DONE: begin
          result <= res_in;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
